crc_append_stage: RTL and testbench

Serial CRC-16 framer directly downstream of the output stage. It takes the eight per-channel serial bit streams and their valid strobes and forwards each frame's data bits with one cycle of latency. Immediately after the last data bit, on the same channel, it appends the 16-bit CRC computed over that frame. Framing and one-hot protocol violations are reported on sticky error flags.

---
 rtl/crc_append_pkg.sv | 25 ++
 rtl/crc16_serial_step.sv | 19 +
 rtl/crc_append_stage.sv | 129 ++++++++++++
 tb/tb_crc_append_stage.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_append_pkg.sv
// Shared types and constants for the serial CRC-16 append stage.
// The receive-side checker uses the same definitions.
package crc_append_pkg;

  localparam int CRC_W = 16;
  localparam logic [CRC_W-1:0] CRC_POLY_DEF = 16'h1021;
  localparam logic [CRC_W-1:0] CRC_INIT_DEF = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    APPEND
  } state_t;

  // Lowest set bit wins when several valids collide.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/crc16_serial_step.sv
// One bit of an MSB-first serial CRC update; purely combinational.
module crc16_serial_step
  import crc_append_pkg::*;
#(
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_POLY_DEF
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc_out
);

  logic fb;

  always_comb begin
    fb      = crc_in[CRC_W-1] ^ bit_in;
    crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  end

endmodule

// File: rtl/crc_append_stage.sv
// Forwards one serial frame per channel with one cycle of latency and
// appends its CRC-16 immediately after the last data bit.
module crc_append_stage
  import crc_append_pkg::*;
#(
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_POLY_DEF,
  parameter logic [CRC_W-1:0] CRC_INIT = CRC_INIT_DEF
) (
  input  logic             clk_out16x,
  input  logic             rst_n,
  input  logic [7:0]       data_in_ch,
  input  logic [7:0]       vld_in_ch,
  input  logic             err_clr,
  output logic [7:0]       frame_out_ch,
  output logic [7:0]       frame_vld_ch,
  output logic             busy,
  output logic [15:0]      frame_len,
  output logic             err_onehot,
  output logic             err_overrun
);

  state_t           state, state_d;
  logic [2:0]       ch_q, ch_d, sel_ch;
  logic [CRC_W-1:0] crc, crc_d, step_in, step_out;
  logic [15:0]      bit_cnt, bit_cnt_d, len_d;
  logic [3:0]       crc_cnt, crc_cnt_d;
  logic [7:0]       out_d, vld_d, ch_mask, others;
  logic             step_bit, multi, onehot_set, overrun_set;

  // A frame start in IDLE seeds the step from CRC_INIT instead of the register.
  always_comb begin
    sel_ch   = (state == IDLE) ? lowest_set(vld_in_ch) : ch_q;
    step_in  = (state == IDLE) ? CRC_INIT : crc;
    step_bit = data_in_ch[sel_ch];
    ch_mask  = 8'b1 << ch_q;
    others   = vld_in_ch & ~ch_mask;
    multi    = |(vld_in_ch & (vld_in_ch - 8'd1));
  end

  crc16_serial_step #(.CRC_POLY(CRC_POLY)) u_step (
    .crc_in  (step_in),
    .bit_in  (step_bit),
    .crc_out (step_out)
  );

  always_comb begin
    state_d     = state;
    ch_d        = ch_q;
    crc_d       = crc;
    bit_cnt_d   = bit_cnt;
    crc_cnt_d   = crc_cnt;
    out_d       = '0;
    vld_d       = '0;
    len_d       = frame_len;
    onehot_set  = 1'b0;
    overrun_set = 1'b0;
    case (state)
      IDLE: begin
        if (|vld_in_ch) begin
          ch_d       = sel_ch;
          crc_d      = step_out;
          out_d      = {7'b0, step_bit} << sel_ch;
          vld_d      = 8'b1 << sel_ch;
          bit_cnt_d  = 16'd1;
          onehot_set = multi;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (vld_in_ch[ch_q] && (others == 8'd0)) begin
          crc_d = step_out;
          out_d = {7'b0, step_bit} << ch_q;
          vld_d = ch_mask;
          if (bit_cnt != 16'hFFFF) bit_cnt_d = bit_cnt + 16'd1;
        end else begin
          // First CRC bit goes out on the same edge the frame closes.
          len_d      = bit_cnt;
          out_d      = {7'b0, crc[CRC_W-1]} << ch_q;
          vld_d      = ch_mask;
          crc_d      = {crc[CRC_W-2:0], 1'b0};
          crc_cnt_d  = 4'd1;
          onehot_set = |others;
          state_d    = APPEND;
        end
      end
      APPEND: begin
        out_d       = {7'b0, crc[CRC_W-1]} << ch_q;
        vld_d       = ch_mask;
        crc_d       = {crc[CRC_W-2:0], 1'b0};
        crc_cnt_d   = crc_cnt + 4'd1;
        overrun_set = |vld_in_ch;
        if (crc_cnt == 4'd15) begin
          crc_d   = CRC_INIT;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_out16x or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ch_q         <= '0;
      crc          <= CRC_INIT;
      bit_cnt      <= '0;
      crc_cnt      <= '0;
      frame_out_ch <= '0;
      frame_vld_ch <= '0;
      busy         <= 1'b0;
      frame_len    <= '0;
      err_onehot   <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      state        <= state_d;
      ch_q         <= ch_d;
      crc          <= crc_d;
      bit_cnt      <= bit_cnt_d;
      crc_cnt      <= crc_cnt_d;
      frame_out_ch <= out_d;
      frame_vld_ch <= vld_d;
      busy         <= (state_d != IDLE);
      frame_len    <= len_d;
      err_onehot   <= err_clr ? 1'b0 : (err_onehot | onehot_set);
      err_overrun  <= err_clr ? 1'b0 : (err_overrun | overrun_set);
    end
  end

endmodule

// File: tb/tb_crc_append_stage.sv
// Directed bench for crc_append_stage: known CRC-16/CCITT vectors plus
// error, back-to-back and mid-frame reset scenarios.
module tb_crc_append_stage;

  logic        clk_out16x = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_clr = 1'b0;
  logic [7:0]  data_in_ch = '0;
  logic [7:0]  vld_in_ch = '0;
  logic [7:0]  frame_out_ch;
  logic [7:0]  frame_vld_ch;
  logic        busy;
  logic [15:0] frame_len;
  logic        err_onehot;
  logic        err_overrun;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int stray = 0;

  logic [7:0] cap_vld[$];
  logic [7:0] cap_dat[$];
  int         cap_cyc[$];

  int           c_n;
  logic         c_contig;
  logic         c_vld_same;
  logic         c_leak;
  logic [7:0]   c_vld;
  logic [15:0]  c_crc;
  logic [127:0] c_data;
  logic         busy_mid;

  crc_append_stage dut (
    .clk_out16x   (clk_out16x),
    .rst_n        (rst_n),
    .data_in_ch   (data_in_ch),
    .vld_in_ch    (vld_in_ch),
    .err_clr      (err_clr),
    .frame_out_ch (frame_out_ch),
    .frame_vld_ch (frame_vld_ch),
    .busy         (busy),
    .frame_len    (frame_len),
    .err_onehot   (err_onehot),
    .err_overrun  (err_overrun)
  );

  always #5 clk_out16x = ~clk_out16x;

  // Record every valid output cycle; outputs only move on posedge.
  always @(negedge clk_out16x) begin
    cyc++;
    if (frame_vld_ch != 8'd0) begin
      cap_vld.push_back(frame_vld_ch);
      cap_dat.push_back(frame_out_ch);
      cap_cyc.push_back(cyc);
    end else if (frame_out_ch != 8'd0) begin
      stray++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_out16x);
  endtask

  task automatic send_bits(input int ch, input int n, input logic [127:0] bits);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_out16x);
      vld_in_ch  = 8'b1 << ch;
      data_in_ch = {7'b0, bits[n-1-i]} << ch;
      if (i == n - 1) busy_mid = busy;
    end
    @(negedge clk_out16x);
    vld_in_ch  = '0;
    data_in_ch = '0;
  endtask

  // Split the captured cycles since base into data bits and trailing CRC.
  task automatic collect(input int base);
    int sz;
    int ch;
    sz         = cap_vld.size();
    c_n        = sz - base;
    c_vld      = (c_n > 0) ? cap_vld[base] : 8'd0;
    c_vld_same = 1'b1;
    c_leak     = 1'b0;
    c_crc      = '0;
    c_data     = '0;
    ch         = 0;
    for (int j = 0; j < 8; j++) if (c_vld[j]) ch = j;
    for (int k = base; k < sz; k++) begin
      if (cap_vld[k] != c_vld) c_vld_same = 1'b0;
      if ((cap_dat[k] & ~cap_vld[k]) != 8'd0) c_leak = 1'b1;
      if (k < sz - 16) c_data = {c_data[126:0], cap_dat[k][ch]};
      else c_crc = {c_crc[14:0], cap_dat[k][ch]};
    end
    c_contig = (c_n > 0) && (cap_cyc[sz-1] - cap_cyc[base] == c_n - 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    n_checks++; if (frame_out_ch !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_out: got %h expected 00", frame_out_ch); end
    n_checks++; if (frame_vld_ch !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_vld: got %h expected 00", frame_vld_ch); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (frame_len !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_len: got %0d expected 0", frame_len); end
    n_checks++; if ({err_onehot, err_overrun} !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 00", {err_onehot, err_overrun}); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_check_string();
    int base;
    base = cap_vld.size();
    send_bits(2, 72, 128'h313233343536373839);
    idle(20);
    collect(base);
    n_checks++; if (busy_mid !== 1'b1) begin n_fail++; $display("[TB] FAIL str_busy_mid: got %b expected 1", busy_mid); end
    n_checks++; if (c_n !== 88) begin n_fail++; $display("[TB] FAIL str_count: got %0d expected 88", c_n); end
    n_checks++; if (c_vld !== 8'h04 || !c_vld_same) begin n_fail++; $display("[TB] FAIL str_vld: got %h same=%b expected 04", c_vld, c_vld_same); end
    n_checks++; if (c_contig !== 1'b1) begin n_fail++; $display("[TB] FAIL str_contig: got %b expected 1", c_contig); end
    n_checks++; if (c_data !== 128'h313233343536373839) begin n_fail++; $display("[TB] FAIL str_data: got %h expected 313233343536373839", c_data); end
    n_checks++; if (c_crc !== 16'h29B1) begin n_fail++; $display("[TB] FAIL str_crc: got %h expected 29b1", c_crc); end
    n_checks++; if (frame_len !== 16'd72) begin n_fail++; $display("[TB] FAIL str_len: got %0d expected 72", frame_len); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL str_busy_end: got %b expected 0", busy); end
    n_checks++; if (c_leak !== 1'b0) begin n_fail++; $display("[TB] FAIL str_leak: got %b expected 0", c_leak); end
  endtask

  task automatic test_zero_byte();
    int base;
    base = cap_vld.size();
    send_bits(7, 8, 128'h0);
    idle(20);
    collect(base);
    n_checks++; if (c_n !== 24) begin n_fail++; $display("[TB] FAIL zero_count: got %0d expected 24", c_n); end
    n_checks++; if (c_vld !== 8'h80 || !c_vld_same) begin n_fail++; $display("[TB] FAIL zero_vld: got %h same=%b expected 80", c_vld, c_vld_same); end
    n_checks++; if (c_crc !== 16'hE1F0) begin n_fail++; $display("[TB] FAIL zero_crc: got %h expected e1f0", c_crc); end
    n_checks++; if (frame_len !== 16'd8) begin n_fail++; $display("[TB] FAIL zero_len: got %0d expected 8", frame_len); end
  endtask

  task automatic test_single_bit();
    int base;
    base = cap_vld.size();
    send_bits(3, 1, 128'h0);
    idle(20);
    collect(base);
    n_checks++; if (c_n !== 17) begin n_fail++; $display("[TB] FAIL single_count: got %0d expected 17", c_n); end
    n_checks++; if (c_vld !== 8'h08 || !c_contig) begin n_fail++; $display("[TB] FAIL single_vld: got %h contig=%b expected 08", c_vld, c_contig); end
    n_checks++; if (c_crc !== 16'hEFDF) begin n_fail++; $display("[TB] FAIL single_crc: got %h expected efdf", c_crc); end
    n_checks++; if (frame_len !== 16'd1) begin n_fail++; $display("[TB] FAIL single_len: got %0d expected 1", frame_len); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = cap_vld.size();
    send_bits(1, 8, 128'h0);
    send_bits(1, 8, 128'hFF);
    idle(20);
    collect(base);
    n_checks++; if (c_n !== 24) begin n_fail++; $display("[TB] FAIL b2b_count: got %0d expected 24", c_n); end
    n_checks++; if (c_crc !== 16'hE1F0) begin n_fail++; $display("[TB] FAIL b2b_crc: got %h expected e1f0", c_crc); end
    n_checks++; if (err_overrun !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_overrun: got %b expected 1", err_overrun); end
    n_checks++; if (err_onehot !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_onehot: got %b expected 0", err_onehot); end
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    n_checks++; if (err_overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_clear: got %b expected 0", err_overrun); end
  endtask

  task automatic test_onehot_conflict();
    int base;
    base = cap_vld.size();
    @(negedge clk_out16x);
    vld_in_ch  = 8'h05;
    data_in_ch = 8'h00;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_out16x);
      vld_in_ch = 8'h01;
    end
    @(negedge clk_out16x);
    vld_in_ch = 8'h00;
    idle(20);
    collect(base);
    n_checks++; if (err_onehot !== 1'b1) begin n_fail++; $display("[TB] FAIL oh_flag: got %b expected 1", err_onehot); end
    n_checks++; if (c_vld !== 8'h01 || !c_vld_same) begin n_fail++; $display("[TB] FAIL oh_vld: got %h same=%b expected 01", c_vld, c_vld_same); end
    n_checks++; if (c_n !== 24) begin n_fail++; $display("[TB] FAIL oh_count: got %0d expected 24", c_n); end
    n_checks++; if (c_crc !== 16'hE1F0) begin n_fail++; $display("[TB] FAIL oh_crc: got %h expected e1f0", c_crc); end
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    n_checks++; if (err_onehot !== 1'b0) begin n_fail++; $display("[TB] FAIL oh_clear: got %b expected 0", err_onehot); end
  endtask

  task automatic test_channel_switch();
    int base;
    base = cap_vld.size();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_out16x);
      vld_in_ch  = 8'h02;
      data_in_ch = 8'h00;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_out16x);
      vld_in_ch  = 8'h10;
      data_in_ch = 8'h10;
    end
    @(negedge clk_out16x);
    vld_in_ch  = 8'h00;
    data_in_ch = 8'h00;
    idle(20);
    collect(base);
    n_checks++; if (c_n !== 24) begin n_fail++; $display("[TB] FAIL sw_count: got %0d expected 24", c_n); end
    n_checks++; if (c_vld !== 8'h02 || !c_vld_same) begin n_fail++; $display("[TB] FAIL sw_vld: got %h same=%b expected 02", c_vld, c_vld_same); end
    n_checks++; if (c_crc !== 16'hE1F0) begin n_fail++; $display("[TB] FAIL sw_crc: got %h expected e1f0", c_crc); end
    n_checks++; if (frame_len !== 16'd8) begin n_fail++; $display("[TB] FAIL sw_len: got %0d expected 8", frame_len); end
    n_checks++; if (err_onehot !== 1'b1) begin n_fail++; $display("[TB] FAIL sw_onehot: got %b expected 1", err_onehot); end
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid_append();
    int base;
    send_bits(6, 8, 128'hA5);
    idle(7);
    n_checks++; if (frame_vld_ch !== 8'h40) begin n_fail++; $display("[TB] FAIL rst_pre_vld: got %h expected 40", frame_vld_ch); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (frame_vld_ch !== 8'd0 || frame_out_ch !== 8'd0) begin n_fail++; $display("[TB] FAIL rst_async_out: got vld %h out %h expected 00 00", frame_vld_ch, frame_out_ch); end
    n_checks++; if (busy !== 1'b0 || frame_len !== 16'd0) begin n_fail++; $display("[TB] FAIL rst_async_state: got busy %b len %0d expected 0 0", busy, frame_len); end
    idle(1);
    rst_n = 1'b1;
    idle(2);
    base = cap_vld.size();
    send_bits(5, 72, 128'h313233343536373839);
    idle(20);
    collect(base);
    n_checks++; if (c_n !== 88 || c_vld !== 8'h20) begin n_fail++; $display("[TB] FAIL rst_next_frame: got %0d cycles vld %h expected 88 20", c_n, c_vld); end
    n_checks++; if (c_crc !== 16'h29B1) begin n_fail++; $display("[TB] FAIL rst_next_crc: got %h expected 29b1", c_crc); end
    n_checks++; if (stray !== 0) begin n_fail++; $display("[TB] FAIL stray_out: got %0d expected 0", stray); end
  endtask

  initial begin
    test_reset();
    test_check_string();
    test_zero_byte();
    test_single_bit();
    test_back_to_back();
    test_onehot_conflict();
    test_channel_switch();
    test_reset_mid_append();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
